bidir_turnaround_ctrl: RTL and testbench
========================================

BIDIR_TURNAROUND_CTRL -- requirements
Module: bidir_turnaround_ctrl

Interface
REQ-001 The parameter ASIZE SHALL default to 4 and sets the FIFO address width, which is informational and bounds MAX_BURST to at most 2**ASIZE.
REQ-002 The parameter MAX_BURST SHALL default to 16 and sets the number of words written per token hold, with a valid range of 1..2**ASIZE.
REQ-003 The parameter HOLDOFF SHALL default to 4 and sets the guard cycles after each a_dir change, with a valid range of 1..15.
REQ-004 The ports SHALL be exactly as follows (clock and reset first):
- a_clk, input, 1: the sole clock.
- a_rst, input, 1: reset, synchronous and active-high.
- tx_req, input, 1: the local side has data to send.
- tx_valid, input, 1: the local write word is valid.
- tx_ready, output, 1: the local write word is accepted this cycle.
- rx_ready, input, 1: the local consumer can take a word.
- rx_valid, output, 1: a read word is presented this cycle.
- a_full, input, 1: FIFO full, A side.
- a_empty, input, 1: FIFO empty, A side.
- a_winc, output, 1: FIFO write strobe.
- a_rinc, output, 1: FIFO read strobe.
- a_dir, output, 1: 1 = A writes, 0 = A reads.
- tok_req, output, 1: level request for write ownership, sent to the peer.
- tok_gnt, input, 1: grant level from the peer, asynchronous to a_clk.
- busy, output, 1: the FSM is not in IDLE.

Function
REQ-005 tok_gnt SHALL pass through a 2-flop synchronizer to form tok_gnt_s, and no logic SHALL use the raw tok_gnt.
REQ-006 The FSM SHALL have exactly six states: IDLE, REQ, GUARD_TX, TX, RELEASE and GUARD_RX.
REQ-007 IDLE behaviour:
- Outputs: a_dir=0, tok_req=0.
- Read path: rx_valid=!a_empty, a_rinc=rx_ready&!a_empty.
- Transition: tx_req=1 -> REQ.
REQ-008 REQ behaviour:
- Outputs: a_dir=0, tok_req=1.
- Read path: stays enabled as in IDLE.
- Transition: tok_gnt_s=1 -> GUARD_TX, with a_dir=1 from the first GUARD_TX cycle.
REQ-009 GUARD_TX behaviour:
- Outputs: a_dir=1, tok_req=1, tx_ready=0, a_winc=0, a_rinc=0.
- Transition: after exactly HOLDOFF cycles -> TX, with the burst counter cleared.
REQ-010 TX behaviour:
- Outputs: tx_ready=!a_full, a_winc=tx_valid&!a_full.
- Burst counter: increments on each a_winc.
- Transition: -> RELEASE on any of the following: tx_req=0; the counter reaches MAX_BURST on this write; tok_gnt_s=0 (peer revoke).
REQ-011 RELEASE behaviour:
- Outputs: a_dir=1, tok_req=0, no strobes.
- Transition: tok_gnt_s=0 -> GUARD_RX.
REQ-012 The peer drops the grant only after its read side has drained.
REQ-013 GUARD_RX behaviour:
- Outputs: a_dir=0, no strobes.
- Transition: after exactly HOLDOFF cycles -> IDLE.
REQ-014 a_winc and a_rinc SHALL never be 1 in the same cycle.
REQ-015 a_winc=1 SHALL occur only when a_dir=1, and a_rinc=1 only when a_dir=0.
REQ-016 a_dir SHALL change only on the REQ->GUARD_TX and RELEASE->GUARD_RX transitions.
REQ-017 tx_ready and a_winc SHALL be 0 in every state except TX, and rx_valid and a_rinc SHALL be 0 in every state except IDLE and REQ.
REQ-018 The burst counter SHALL be ASIZE+1 bits wide and SHALL never exceed MAX_BURST.
REQ-019 When a_full=1 in TX, the FSM SHALL stall in TX with no write and no count increment.
REQ-020 When tx_req falls on the same cycle as the last MAX_BURST write, the FSM SHALL make a single RELEASE transition and SHALL count the write.
REQ-021 When tx_req=1 persists after a MAX_BURST release, the FSM SHALL return to IDLE and then REQ, so the peer always gets a turnaround opportunity.
REQ-022 When the peer revokes in GUARD_TX, the FSM SHALL still complete the guard and SHALL then exit TX to RELEASE on its first cycle with no write.

Reset
REQ-023 With a_rst=1 at a rising a_clk edge, the following SHALL hold on the next cycle:
- FSM in IDLE.
- Synchronizer flops, burst counter and guard counter all 0.
- a_dir=0, tok_req=0, busy=0, a_winc=0, a_rinc=0, tx_ready=0.
- rx_valid follows !a_empty.
REQ-024 A reset asserted mid-TX SHALL abort immediately, with no further a_winc after the reset edge.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- Basic burst: tx_req=1, tok_gnt raised 3 cycles after tok_req, tx_valid=1. Required: a_dir=1 exactly 2 sync cycles after tok_gnt, then 4 guard cycles, then 16 a_winc pulses, then tok_req=0.
- Full stall: a_full=1 for cycles 5-8 of TX. Required: no a_winc in those cycles, and the count resumes at 5.
- Short burst: tx_req dropped after 3 writes. Required: RELEASE with count=3; after tok_gnt=0, a_dir=0 two cycles later, then 4 guard cycles, then IDLE.
- Peer revoke: tok_gnt drops mid-TX at count=7. Required: RELEASE within 2 cycles and no write after the synchronized drop.
- Reset mid-burst: a_rst=1 at count=9. Required: the next cycle has a_dir=0, tok_req=0, a_winc=0.
- Invariant check: random stimulus over 10k cycles with a_winc&a_rinc never 1, a_winc only when a_dir=1, and a_rinc only when a_dir=0.

Source files
------------

// File: rtl/bidir_turnaround_ctrl.sv
// Token-based direction controller for a shared bidirectional FIFO port.
// Requests write ownership from the peer, guards each a_dir change, and bursts writes.
module bidir_turnaround_ctrl #(
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic a_clk,
  input  logic a_rst,
  input  logic tx_req,
  input  logic tx_valid,
  output logic tx_ready,
  input  logic rx_ready,
  output logic rx_valid,
  input  logic a_full,
  input  logic a_empty,
  output logic a_winc,
  output logic a_rinc,
  output logic a_dir,
  output logic tok_req,
  input  logic tok_gnt,
  output logic busy
);

  localparam int unsigned CW = ASIZE + 1;
  localparam int unsigned GW = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    GUARD_TX = 3'd2,
    TX       = 3'd3,
    RELEASE  = 3'd4,
    GUARD_RX = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
  logic            tok_gnt_s;
  logic [CW-1:0]   burst_inc;
  logic            wr_ok;
  logic            guard_done;

  assign tok_gnt_s  = sync2_q;
  assign busy       = (state_q != IDLE);
  assign burst_inc  = burst_cnt_q + CW'(1);
  assign guard_done = (guard_cnt_q == GW'(HOLDOFF - 1));

  // State and synchronizer registers
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      burst_cnt_q <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      burst_cnt_q <= burst_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d     = state_q;
    sync1_d     = tok_gnt;
    sync2_d     = sync1_q;
    burst_cnt_d = burst_cnt_q;
    guard_cnt_d = guard_cnt_q;
    a_dir       = 1'b0;
    tok_req     = 1'b0;
    tx_ready    = 1'b0;
    a_winc      = 1'b0;
    a_rinc      = 1'b0;
    rx_valid    = 1'b0;
    wr_ok       = 1'b0;

    case (state_q)
      IDLE: begin
        rx_valid = !a_empty;
        a_rinc   = rx_ready & !a_empty;
        if (tx_req) state_d = REQ;
      end
      REQ: begin
        tok_req  = 1'b1;
        rx_valid = !a_empty;
        a_rinc   = rx_ready & !a_empty;
        if (tok_gnt_s) begin
          state_d     = GUARD_TX;
          guard_cnt_d = '0;
        end
      end
      GUARD_TX: begin
        a_dir   = 1'b1;
        tok_req = 1'b1;
        if (guard_done) begin
          state_d     = TX;
          guard_cnt_d = '0;
          burst_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      TX: begin
        a_dir    = 1'b1;
        tok_req  = 1'b1;
        // A revoked grant blocks the write even before the exit takes effect
        wr_ok    = !a_full & tok_gnt_s;
        tx_ready = wr_ok;
        a_winc   = tx_valid & wr_ok;
        if (a_winc) burst_cnt_d = burst_inc;
        if (!tx_req || !tok_gnt_s || (a_winc && (burst_inc == CW'(MAX_BURST))))
          state_d = RELEASE;
      end
      RELEASE: begin
        a_dir = 1'b1;
        if (!tok_gnt_s) begin
          state_d     = GUARD_RX;
          guard_cnt_d = '0;
        end
      end
      GUARD_RX: begin
        if (guard_done) begin
          state_d     = IDLE;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bidir_turnaround_ctrl.sv
// Directed and randomized checks of bidir_turnaround_ctrl with default parameters.
module tb_bidir_turnaround_ctrl;

  logic a_clk, a_rst;
  logic tx_req, tx_valid, tx_ready;
  logic rx_ready, rx_valid;
  logic a_full, a_empty;
  logic a_winc, a_rinc, a_dir;
  logic tok_req, tok_gnt, busy;

  int checks = 0;
  int fails  = 0;

  bidir_turnaround_ctrl dut (
    .a_clk    (a_clk),
    .a_rst    (a_rst),
    .tx_req   (tx_req),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .a_full   (a_full),
    .a_empty  (a_empty),
    .a_winc   (a_winc),
    .a_rinc   (a_rinc),
    .a_dir    (a_dir),
    .tok_req  (tok_req),
    .tok_gnt  (tok_gnt),
    .busy     (busy)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  // Raise the grant from REQ; returns in the last GUARD_TX cycle.
  task automatic to_tx();
    tok_gnt = 1'b1;
    repeat (6) tick();
    #1;
    chk("guard_last_dir", a_dir, 1'b1);
    chk("guard_last_rdy", tx_ready, 1'b0);
  endtask

  // Four GUARD_RX cycles then IDLE.
  task automatic rx_guard();
    repeat (4) begin
      tick(); #1;
      chk("grx_dir", a_dir, 1'b0);
      chk("grx_busy", busy, 1'b1);
      chk("grx_winc", a_winc, 1'b0);
    end
    tick(); #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_dir", a_dir, 1'b0);
  endtask

  // Called in the first RELEASE cycle: drop the grant and follow it through.
  task automatic finish_release();
    tok_gnt = 1'b0;
    repeat (2) begin
      tick(); #1;
      chk("rel_dir", a_dir, 1'b1);
      chk("rel_tokreq", tok_req, 1'b0);
    end
    rx_guard();
  endtask

  initial begin
    a_rst = 1'b1; tx_req = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
    a_full = 1'b0; a_empty = 1'b1; tok_gnt = 1'b0;

    // Reset state
    repeat (2) tick();
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_dir", a_dir, 1'b0);
    chk("rst_tokreq", tok_req, 1'b0);
    chk("rst_winc", a_winc, 1'b0);
    chk("rst_rinc", a_rinc, 1'b0);
    chk("rst_txrdy", tx_ready, 1'b0);
    chk("rst_rxv_empty", rx_valid, 1'b0);
    a_empty = 1'b0; rx_ready = 1'b1; #1;
    chk("rst_rxv_data", rx_valid, 1'b1);
    chk("idle_rinc", a_rinc, 1'b1);
    a_empty = 1'b1; rx_ready = 1'b0;

    // Basic burst
    a_rst = 1'b0; tx_req = 1'b1; tx_valid = 1'b1;
    tick(); #1;
    chk("req_tokreq", tok_req, 1'b1);
    chk("req_busy", busy, 1'b1);
    chk("req_dir", a_dir, 1'b0);
    tick();
    a_empty = 1'b0; rx_ready = 1'b1; #1;
    chk("req_rinc", a_rinc, 1'b1);
    a_empty = 1'b1; rx_ready = 1'b0;
    tick();
    tok_gnt = 1'b1;
    repeat (2) begin
      tick(); #1;
      chk("sync_dir_low", a_dir, 1'b0);
    end
    tick(); #1;
    chk("gtx_dir_high", a_dir, 1'b1);
    chk("gtx_winc0", a_winc, 1'b0);
    repeat (3) begin
      tick(); #1;
      chk("gtx_winc", a_winc, 1'b0);
      chk("gtx_rdy", tx_ready, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      tick(); #1;
      chk("burst_winc", a_winc, 1'b1);
    end
    tick(); #1;
    chk("max_rel_tokreq", tok_req, 1'b0);
    chk("max_rel_dir", a_dir, 1'b1);
    chk("max_rel_winc", a_winc, 1'b0);
    finish_release();
    tick(); #1;
    chk("rereq_tokreq", tok_req, 1'b1);

    // Full stall at TX cycles 5-8; tx_req falls on the 16th write
    to_tx();
    for (int c = 1; c <= 20; c++) begin
      tick();
      a_full = (c >= 5 && c <= 8);
      if (c == 20) tx_req = 1'b0;
      #1;
      chk("stall_winc", a_winc, !a_full);
      chk("stall_rdy", tx_ready, !a_full);
    end
    a_full = 1'b0;
    tick(); #1;
    chk("stall_rel_tokreq", tok_req, 1'b0);
    chk("stall_rel_dir", a_dir, 1'b1);
    finish_release();
    tick(); #1;
    chk("stay_idle", busy, 1'b0);

    // Short burst: tx_req falls with the third write
    tx_req = 1'b1;
    tick(); #1;
    chk("s3_req", tok_req, 1'b1);
    to_tx();
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) tx_req = 1'b0;
      #1;
      chk("short_winc", a_winc, 1'b1);
    end
    tick(); #1;
    chk("short_rel_tokreq", tok_req, 1'b0);
    chk("short_rel_winc", a_winc, 1'b0);
    finish_release();

    // Peer revoke at count 7
    tx_req = 1'b1;
    tick();
    to_tx();
    for (int c = 1; c <= 7; c++) begin
      tick(); #1;
      chk("rvk_winc", a_winc, 1'b1);
    end
    tok_gnt = 1'b0;
    tick(); #1;
    chk("rvk_lag_winc", a_winc, 1'b1);
    tick(); #1;
    chk("rvk_nowrite", a_winc, 1'b0);
    chk("rvk_rdy", tx_ready, 1'b0);
    tx_req = 1'b0;
    tick(); #1;
    chk("rvk_rel_tokreq", tok_req, 1'b0);
    chk("rvk_rel_dir", a_dir, 1'b1);
    rx_guard();

    // Revoke during GUARD_TX
    tx_req = 1'b1;
    tick();
    tok_gnt = 1'b1;
    repeat (2) tick();
    tick();
    tok_gnt = 1'b0; a_empty = 1'b0; rx_ready = 1'b1; #1;
    chk("gr_dir", a_dir, 1'b1);
    chk("gr_rinc", a_rinc, 1'b0);
    chk("gr_rxv", rx_valid, 1'b0);
    repeat (3) begin
      tick(); #1;
      chk("gr_guard_dir", a_dir, 1'b1);
      chk("gr_guard_winc", a_winc, 1'b0);
    end
    tick(); #1;
    chk("gr_tx_winc", a_winc, 1'b0);
    chk("gr_tx_rdy", tx_ready, 1'b0);
    chk("gr_tx_tokreq", tok_req, 1'b1);
    tx_req = 1'b0; a_empty = 1'b1; rx_ready = 1'b0;
    tick(); #1;
    chk("gr_rel_tokreq", tok_req, 1'b0);
    chk("gr_rel_dir", a_dir, 1'b1);
    rx_guard();

    // Reset mid-burst at count 9
    tx_req = 1'b1;
    tick();
    to_tx();
    for (int c = 1; c <= 9; c++) begin
      tick(); #1;
      chk("rb_winc", a_winc, 1'b1);
    end
    a_rst = 1'b1;
    tick(); #1;
    chk("rb_dir", a_dir, 1'b0);
    chk("rb_tokreq", tok_req, 1'b0);
    chk("rb_winc_after", a_winc, 1'b0);
    chk("rb_busy", busy, 1'b0);
    chk("rb_rdy", tx_ready, 1'b0);
    a_rst = 1'b0; tx_req = 1'b0; tok_gnt = 1'b0;
    tick(); #1;
    chk("rb_idle", busy, 1'b0);

    // Random invariants
    for (int n = 0; n < 10000; n++) begin
      tick();
      tx_req   = 1'($urandom_range(0, 3) != 0);
      tx_valid = 1'($urandom_range(0, 1));
      rx_ready = 1'($urandom_range(0, 1));
      a_full   = 1'($urandom_range(0, 3) == 0);
      a_empty  = 1'($urandom_range(0, 1));
      a_rst    = 1'($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 15) == 0) tok_gnt = ~tok_gnt;
      #1;
      chk("inv_excl", a_winc & a_rinc, 1'b0);
      chk("inv_winc_dir", a_winc & !a_dir, 1'b0);
      chk("inv_rinc_dir", a_rinc & a_dir, 1'b0);
      chk("inv_winc_rdy", a_winc & !tx_ready, 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
